la_host_sequencer: RTL and testbench
====================================

# la_host_sequencer

Hardware initiator for the logic-analyzer operand-loading protocol: drives the 128-bit command/data word toward the accelerator slave and interprets its 128-bit status word. It sequences enter-write, fourteen 82-bit operand chunk transfers, start-processing, four result read-backs and return-to-idle. It lets the accelerator be exercised from on-chip logic or a bench harness without firmware bit-banging LA registers.

## Interface
- `HOLD`, default 2: minimum cycles a drive word is held before the status word may be compared.
- `TIMEOUT`, default 4096: maximum cycles spent in any single wait before abort.
- `wb_clk_i` input 1: sole clock, rising edge.
- `wb_rst_i` input 1: reset, synchronous, active-high.
- `start` input 1: begin a full transaction; sampled only in IDLE.
- `chunk_data` input 82: operand chunk payload.
- `chunk_valid` input 1: chunk_data valid.
- `chunk_ready` output 1: chunk accepted on `chunk_valid & chunk_ready`.
- `la_cmd_o` output 128: word driven to the slave's LA input.
- `la_status_i` input 128: slave's LA output word.
- `result_data` output 82: captured read-back chunk.
- `result_idx` output 2: index 0..3 of result_data.
- `result_valid` output 1: one-cycle pulse per captured result.
- `busy` output 1: high from start acceptance until done.
- `done` output 1: one-cycle pulse at end of transaction.
- `err` output 1: set on timeout; cleared on next accepted start.

## Operation
- Drive word fields: cmd = [31:16], tag = [95:82], payload = [81:0]. All other bits 0.
- States: IDLE, ENTER, LOAD, LACK, PROC, READ, EXIT.
- IDLE: la_cmd_o = 0. `start` → ENTER, busy=1, err=0, chunk counter k=1.
- ENTER: cmd=0xAB40, tag=0, held HOLD cycles → LOAD.
- LOAD: cmd=0xAB40, chunk_ready=1. On handshake: tag = thermometer of k ones (k LSBs set, e.g. k=3 → 14'b00000000000111), payload = chunk_data → LACK.
- LACK: wait for ack. For k<14, ack is status[125:122]==k. For k=14, ack is status[127:122]==6'b011110. On ack with k<14: k++, → LOAD. On ack with k=14 → PROC.
- PROC: cmd=0xAB41, tag=0, payload=0. Wait status[127:122]==6'b100111 (processing), then wait status[127:126]==2'b11 with [127:122]!=6'b100111 (read mode). Then → READ with idx=0.
- READ: cmd selects by idx: 0→0x0000, 1→0x0400, 2→0x0800, 3→0x0C00. Expected status[127:114] by idx: 0→14'b11000100000000, 1→14'b11001000000000, 2→14'b11001100000000, 3→14'b11010000000000.
  - On match: result_data=status[113:32], result_idx=idx, result_valid pulse.
  - idx<3 → idx++. idx=3 → EXIT.
- EXIT: cmd=0x1000. Wait status[127:122]==6'b010000 (slave idle), then done pulse, busy=0 → IDLE.
- Timeout: any wait exceeding TIMEOUT cycles sets err=1 → EXIT. Timeout in EXIT itself → IDLE with done pulse.
- `start` while busy: ignored. `chunk_valid` outside LOAD: ignored, chunk_ready=0.

## Timing
- All outputs registered. Reset (or any reset mid-operation) forces: la_cmd_o=0, chunk_ready=0, result_data=0, result_idx=0, result_valid=0, busy=0, done=0, err=0, state IDLE, all counters 0.
- Hold counter restarts whenever la_cmd_o changes. Status compares are ignored until ≥HOLD cycles of hold; this rejects stale acks from the previous step.
- Timeout counter restarts on each state entry or drive-word change. Expiry occurs when the count reaches TIMEOUT.
- Start accepted at edge N: busy=1 and la_cmd_o[31:16]=0xAB40 visible at N+1.
- Chunk handshake at edge N: the tagged word is visible at N+1 and chunk_ready=0 until the ack is accepted.
- Minimum per-chunk cycle: HOLD+1. Back-to-back chunk_valid is allowed.
- result_valid asserts the cycle after the matching compare. done asserts the cycle after the idle-status compare.
- Status match and timeout expiry on the same cycle: match wins.

## Test plan
- Reset mid-LACK (k=5): assert wb_rst_i one cycle → next cycle all outputs 0, state IDLE. Subsequent start runs a clean transaction from k=1.
- Full transaction against a behavioural slave model with 14 chunks 0x1..0xE (zero-extended) → tags 1..14 ones in order, 0xAB41 issued after ack 6'b011110, four result_valid pulses idx 0..3 with model data, done, err=0.
- Slave acks chunk 7 after 50 cycles while chunk_valid stays high → chunk 8 not consumed before ack; la_cmd_o stable throughout the wait.
- Stale ack: the model leaves status[125:122]=3 when tag 4 is driven → no advance until status becomes 4.
- Slave never leaves processing: with TIMEOUT=64 → err=1 after 64 cycles in PROC, cmd 0x1000 driven, done after idle status, no result_valid.
- start pulsed during READ → ignored. A second start after done → err cleared, new transaction begins.

Source files
------------

// File: rtl/la_host_sequencer_if.sv
// Chunk stream, LA command/status words and result stream between the
// sequencer (master) and the environment that feeds and observes it (slave).
interface la_host_sequencer_if;
  logic [81:0]  chunk_data;
  logic         chunk_valid;
  logic         chunk_ready;
  logic [127:0] la_cmd_o;
  logic [127:0] la_status_i;
  logic [81:0]  result_data;
  logic [1:0]   result_idx;
  logic         result_valid;

  modport master (
    input  chunk_data, chunk_valid, la_status_i,
    output chunk_ready, la_cmd_o, result_data, result_idx, result_valid
  );

  modport slave (
    output chunk_data, chunk_valid, la_status_i,
    input  chunk_ready, la_cmd_o, result_data, result_idx, result_valid
  );
endinterface

// File: rtl/la_host_sequencer.sv
// Hardware initiator for the LA operand-loading protocol: enter-write, 14 chunk
// writes, start-processing, 4 result read-backs, return-to-idle.
module la_host_sequencer #(
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  la_host_sequencer_if.master bus
);
  localparam int CNT_MAX = (TIMEOUT > HOLD) ? TIMEOUT : HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] SAT_C  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  localparam logic [15:0] CMD_WRITE = 16'hAB40;
  localparam logic [15:0] CMD_PROC  = 16'hAB41;
  localparam logic [15:0] CMD_EXIT  = 16'h1000;

  typedef enum logic [2:0] {IDLE, ENTER, LOAD, LACK, PROC, READ, EXIT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       k_q, k_d;
  logic [1:0]       idx_q, idx_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [127:0]     cmd_q, cmd_d;
  logic             chunk_ready_q, chunk_ready_d;
  logic [81:0]      result_data_q, result_data_d;
  logic [1:0]       result_idx_q, result_idx_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             held, expired, ack, word_chg;
  logic [5:0]       st6;

  function automatic logic [127:0] cmd_word(input logic [15:0] cmd);
    logic [127:0] w;
    w        = '0;
    w[31:16] = cmd;
    return w;
  endfunction

  function automatic logic [13:0] thermo(input logic [3:0] k);
    return 14'((15'd1 << k) - 15'd1);
  endfunction

  function automatic logic [13:0] read_pat(input logic [1:0] idx);
    case (idx)
      2'd0:    return 14'b11000100000000;
      2'd1:    return 14'b11001000000000;
      2'd2:    return 14'b11001100000000;
      default: return 14'b11010000000000;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    idx_d          = idx_q;
    phase_d        = phase_q;
    cmd_d          = cmd_q;
    chunk_ready_d  = 1'b0;
    result_data_d  = result_data_q;
    result_idx_d   = result_idx_q;
    result_valid_d = 1'b0;
    busy_d         = busy_q;
    done_d         = 1'b0;
    err_d          = err_q;
    held    = (hold_q >= HOLD_C);
    expired = (tmo_q >= TMO_C);
    st6     = bus.la_status_i[127:122];
    ack     = (k_q == 4'd14) ? (st6 == 6'b011110) : (bus.la_status_i[125:122] == k_q);

    case (state_q)
      IDLE: if (start) begin
        state_d = ENTER;
        busy_d  = 1'b1;
        err_d   = 1'b0;
        k_d     = 4'd1;
        idx_d   = 2'd0;
        phase_d = 1'b0;
        cmd_d   = cmd_word(CMD_WRITE);
      end
      ENTER: if (held) begin
        state_d       = LOAD;
        chunk_ready_d = 1'b1;
      end
      LOAD: begin
        if (bus.chunk_valid && chunk_ready_q) begin
          // Payload spans [81:0] and so covers the cmd field; the chunk bits win.
          state_d = LACK;
          cmd_d   = {32'd0, thermo(k_q), bus.chunk_data};
        end else if (expired) begin
          state_d = EXIT;
          err_d   = 1'b1;
          cmd_d   = cmd_word(CMD_EXIT);
        end else begin
          chunk_ready_d = 1'b1;
        end
      end
      LACK: begin
        if (held && ack) begin
          if (k_q == 4'd14) begin
            state_d = PROC;
            phase_d = 1'b0;
            cmd_d   = cmd_word(CMD_PROC);
          end else begin
            state_d       = LOAD;
            k_d           = k_q + 4'd1;
            chunk_ready_d = 1'b1;
            cmd_d         = cmd_word(CMD_WRITE);
          end
        end else if (expired) begin
          state_d = EXIT;
          err_d   = 1'b1;
          cmd_d   = cmd_word(CMD_EXIT);
        end
      end
      PROC: begin
        // First see the processing code, then any read-mode code other than it.
        if (held && !phase_q && st6 == 6'b100111) begin
          phase_d = 1'b1;
        end else if (held && phase_q && st6[5:4] == 2'b11 && st6 != 6'b100111) begin
          state_d = READ;
          idx_d   = 2'd0;
          cmd_d   = cmd_word({4'd0, 2'd0, 10'd0});
        end else if (expired) begin
          state_d = EXIT;
          err_d   = 1'b1;
          cmd_d   = cmd_word(CMD_EXIT);
        end
      end
      READ: begin
        if (held && bus.la_status_i[127:114] == read_pat(idx_q)) begin
          result_data_d  = bus.la_status_i[113:32];
          result_idx_d   = idx_q;
          result_valid_d = 1'b1;
          if (idx_q == 2'd3) begin
            state_d = EXIT;
            cmd_d   = cmd_word(CMD_EXIT);
          end else begin
            idx_d = idx_q + 2'd1;
            cmd_d = cmd_word({4'd0, idx_q + 2'd1, 10'd0});
          end
        end else if (expired) begin
          state_d = EXIT;
          err_d   = 1'b1;
          cmd_d   = cmd_word(CMD_EXIT);
        end
      end
      EXIT: begin
        if ((held && st6 == 6'b010000) || expired) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cmd_d   = '0;
          if (!(held && st6 == 6'b010000)) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Hold restarts on any drive-word change; the wait timer also on state entry.
    word_chg = (cmd_d != cmd_q);
    hold_d   = word_chg ? ONE_C : ((hold_q == SAT_C) ? hold_q : hold_q + ONE_C);
    tmo_d    = (word_chg || state_d != state_q) ? ONE_C
             : ((tmo_q == SAT_C) ? tmo_q : tmo_q + ONE_C);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q        <= IDLE;
      k_q            <= '0;
      idx_q          <= '0;
      phase_q        <= 1'b0;
      hold_q         <= '0;
      tmo_q          <= '0;
      cmd_q          <= '0;
      chunk_ready_q  <= 1'b0;
      result_data_q  <= '0;
      result_idx_q   <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      idx_q          <= idx_d;
      phase_q        <= phase_d;
      hold_q         <= hold_d;
      tmo_q          <= tmo_d;
      cmd_q          <= cmd_d;
      chunk_ready_q  <= chunk_ready_d;
      result_data_q  <= result_data_d;
      result_idx_q   <= result_idx_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign bus.la_cmd_o     = cmd_q;
  assign bus.chunk_ready  = chunk_ready_q;
  assign bus.result_data  = result_data_q;
  assign bus.result_idx   = result_idx_q;
  assign bus.result_valid = result_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
endmodule

// File: tb/tb_la_host_sequencer.sv
// Directed/randomized bench for la_host_sequencer; the bench plays the LA slave
// and derives every expected drive word and result from the protocol rules.
module tb_la_host_sequencer;
  localparam int HOLD    = 2;
  localparam int TIMEOUT = 64;
  localparam logic [127:0] W_ENTER = 128'h0000_0000_0000_0000_0000_0000_AB40_0000;
  localparam logic [127:0] W_PROC  = 128'h0000_0000_0000_0000_0000_0000_AB41_0000;
  localparam logic [127:0] W_EXIT  = 128'h0000_0000_0000_0000_0000_0000_1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;
  int   total = 0;
  int   bad = 0;
  int   rv_count = 0;

  la_host_sequencer_if bus();

  la_host_sequencer #(.HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.result_valid === 1'b1) rv_count++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_word(input string tag, input logic [127:0] exp, input int budget, output int n);
    n = 0;
    while (bus.la_cmd_o !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.la_cmd_o, exp);
  endtask

  function automatic logic [127:0] chunk_word(input int k, input logic [81:0] c);
    logic [127:0] ones;
    ones = (128'd1 << k) - 128'd1;
    return (ones << 82) | {46'd0, c};
  endfunction

  function automatic logic [127:0] read_word(input int i);
    return 128'(i) << 26;
  endfunction

  function automatic logic [13:0] read_pat(input int i);
    return 14'h3100 + 14'(i * 256);
  endfunction

  function automatic logic [81:0] rand82(input bit hole);
    logic [81:0] v;
    v = {18'($urandom), 32'($urandom), 32'($urandom)};
    if (hole) v[31:16] = 16'h0;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd"},   bus.la_cmd_o, 128'd0);
    chk({tag, "_ready"}, 128'(bus.chunk_ready), 128'd0);
    chk({tag, "_rdata"}, 128'(bus.result_data), 128'd0);
    chk({tag, "_ridx"},  128'(bus.result_idx), 128'd0);
    chk({tag, "_rv"},    128'(bus.result_valid), 128'd0);
    chk({tag, "_busy"},  128'(busy), 128'd0);
    chk({tag, "_done"},  128'(done), 128'd0);
    chk({tag, "_err"},   128'(err), 128'd0);
  endtask

  // mode 0: plain, 1: stale/slow ack + start in READ, 2: stuck in processing, 3: reset at k=5
  task automatic run_txn(input int mode, input bit fixed);
    logic [81:0]  ch [1:14];
    logic [81:0]  rd [0:3];
    logic [127:0] w;
    int           n, rv0;
    bit           stable;
    for (int k = 1; k <= 14; k++) ch[k] = fixed ? 82'(k) : rand82(1'b1);
    for (int i = 0; i < 4; i++) rd[i] = rand82(1'b0);
    rv0 = rv_count;
    bus.chunk_data  = ch[1];
    bus.chunk_valid = 1'b1;
    tick(1);
    chk("ready_idle", 128'(bus.chunk_ready), 128'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_start", 128'(busy), 128'd1);
    chk("err_start", 128'(err), 128'd0);
    chk("enter_word", bus.la_cmd_o, W_ENTER);

    for (int k = 1; k <= 14; k++) begin
      w = chunk_word(k, ch[k]);
      wait_word("chunk_word", w, 40, n);
      if (k < 14) bus.chunk_data = ch[k+1];
      else bus.chunk_valid = 1'b0;
      if (mode == 3 && k == 5) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_all_zero("mid_reset");
        return;
      end
      if (mode == 1 && (k == 4 || k == 7)) begin
        stable = 1'b1;
        for (int c = 0; c < ((k == 7) ? 50 : 10); c++) begin
          tick(1);
          if (bus.la_cmd_o !== w || bus.chunk_ready !== 1'b0) stable = 1'b0;
        end
        chk("ack_wait_hold", 128'(stable), 128'd1);
      end else begin
        tick(int'($urandom_range(0, 3)));
      end
      bus.la_status_i = (k < 14) ? (128'(k) << 122) : (128'(6'b011110) << 122);
    end

    wait_word("proc_word", W_PROC, 40, n);
    bus.la_status_i = 128'(6'b100111) << 122;
    if (mode == 2) begin
      wait_word("timeout_exit", W_EXIT, 200, n);
      chk("timeout_cycles", 128'(n), 128'd64);
      chk("timeout_err", 128'(err), 128'd1);
    end else begin
      tick(HOLD + 1 + int'($urandom_range(0, 3)));
      bus.la_status_i = {14'h3000, 82'd0, 32'($urandom)};
      for (int i = 0; i < 4; i++) begin
        wait_word("read_word", read_word(i), 40, n);
        if (mode == 1 && i == 2) begin
          start = 1'b1;
          tick(1);
          start = 1'b0;
          chk("busy_in_read", 128'(busy), 128'd1);
        end
        tick(int'($urandom_range(0, 2)));
        bus.la_status_i = {read_pat(i), rd[i], 32'($urandom)};
        n = 0;
        while (bus.result_valid !== 1'b1 && n < 40) begin
          tick(1);
          n++;
        end
        chk("result_valid", 128'(bus.result_valid), 128'd1);
        chk("result_idx", 128'(bus.result_idx), 128'(i));
        chk("result_data", 128'(bus.result_data), 128'(rd[i]));
        tick(1);
        chk("result_pulse", 128'(bus.result_valid), 128'd0);
      end
      wait_word("exit_word", W_EXIT, 40, n);
    end

    tick(int'($urandom_range(0, 3)));
    bus.la_status_i = 128'(6'b010000) << 122;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    chk("done", 128'(done), 128'd1);
    chk("busy_done", 128'(busy), 128'd0);
    chk("err_done", 128'(err), 128'(mode == 2));
    chk("idle_word", bus.la_cmd_o, 128'd0);
    tick(1);
    chk("done_pulse", 128'(done), 128'd0);
    chk("rv_pulses", 128'(rv_count - rv0), 128'((mode == 2) ? 0 : 4));
  endtask

  initial begin
    bus.chunk_data  = '0;
    bus.chunk_valid = 1'b0;
    bus.la_status_i = '0;
    rst = 1'b1;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    run_txn(0, 1'b1);
    run_txn(3, 1'b0);
    run_txn(0, 1'b0);
    run_txn(1, 1'b0);
    run_txn(2, 1'b0);
    run_txn(0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
